// File: rtl/debounce_pkg.sv
// Shared types and helpers for the level debouncer.
package debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    CHK_HI    = 2'd1,
    STABLE_HI = 2'd2,
    CHK_LO    = 2'd3
  } deb_state_t;

  // Width of the consecutive-sample counter; never narrower than one bit.
  function automatic int cnt_width(input int cycles);
    int w;
    w = $clog2(cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sync_ff_chain.sv
// Plain flop-chain synchronizer for a single asynchronous bit.
module sync_ff_chain #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the raw input through the chain; nothing sits between stages.
  always_ff @(posedge clk) begin
    if (rst) chain <= {STAGES{RESET_VAL}};
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/sig_debounce_sync.sv
// Synchronize a raw level, then accept a new level only after
// DEBOUNCE_CYCLES consecutive identical samples; flag aborted attempts.
module sig_debounce_sync
  import debounce_pkg::*;
#(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 4,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic sig_async,
  output logic sig_clean,
  output logic sig_busy,
  output logic glitch_pulse
);

  localparam int            CW      = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic          sig_sync;
  deb_state_t    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          clean_nxt, glitch_nxt;

  sync_ff_chain #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (RESET_LEVEL)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (sig_async),
    .q   (sig_sync)
  );

  // State, counter and registered outputs; reset lands in the reset-level stable state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RESET_LEVEL ? STABLE_HI : STABLE_LO;
      cnt          <= '0;
      sig_clean    <= RESET_LEVEL;
      glitch_pulse <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      sig_clean    <= clean_nxt;
      glitch_pulse <= glitch_nxt;
    end
  end

  // Next-state: a mismatch opens a check, a returning sample aborts it,
  // CNT_MAX+1 matching samples commit the new level.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    clean_nxt  = sig_clean;
    glitch_nxt = 1'b0;
    case (state)
      STABLE_LO: begin
        if (sig_sync) begin
          state_nxt = CHK_HI;
          cnt_nxt   = CNT_ONE;
        end else begin
          cnt_nxt   = '0;
        end
      end
      CHK_HI: begin
        if (!sig_sync) begin
          state_nxt  = STABLE_LO;
          cnt_nxt    = '0;
          glitch_nxt = 1'b1;
        end else if (cnt == CNT_MAX) begin
          state_nxt  = STABLE_HI;
          clean_nxt  = 1'b1;
          cnt_nxt    = '0;
        end else begin
          cnt_nxt    = cnt + CNT_ONE;
        end
      end
      STABLE_HI: begin
        if (!sig_sync) begin
          state_nxt = CHK_LO;
          cnt_nxt   = CNT_ONE;
        end else begin
          cnt_nxt   = '0;
        end
      end
      CHK_LO: begin
        if (sig_sync) begin
          state_nxt  = STABLE_HI;
          cnt_nxt    = '0;
          glitch_nxt = 1'b1;
        end else if (cnt == CNT_MAX) begin
          state_nxt  = STABLE_LO;
          clean_nxt  = 1'b0;
          cnt_nxt    = '0;
        end else begin
          cnt_nxt    = cnt + CNT_ONE;
        end
      end
      default: begin
        // Unknown encoding: fall back to the stable state matching the output.
        state_nxt = sig_clean ? STABLE_HI : STABLE_LO;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign sig_busy = (state == CHK_HI) || (state == CHK_LO);

endmodule

// File: tb/tb_sig_debounce_sync.sv
// Directed bench for sig_debounce_sync at default parameters.
module tb_sig_debounce_sync;
  import debounce_pkg::*;

  logic clk;
  logic rst;
  logic sig_async;
  logic sig_clean;
  logic sig_busy;
  logic glitch_pulse;

  int checks   = 0;
  int failures = 0;

  sig_debounce_sync #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .RESET_LEVEL     (1'b0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sig_async    (sig_async),
    .sig_clean    (sig_clean),
    .sig_busy     (sig_busy),
    .glitch_pulse (glitch_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic c, input logic b, input logic g);
    chk({tag, ".clean"},  32'(sig_clean),    32'(c));
    chk({tag, ".busy"},   32'(sig_busy),     32'(b));
    chk({tag, ".glitch"}, 32'(glitch_pulse), 32'(g));
  endtask

  // Drive the input, let one rising edge sample it, then look at outputs 1ns later.
  task automatic step(input logic a);
    sig_async = a;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    sig_async = 1'b1;

    // Reset held with input high: outputs pinned low.
    for (int i = 1; i <= 3; i++) begin
      step(1'b1);
      chk3($sformatf("rst%0d", i), 1'b0, 1'b0, 1'b0);
    end
    chk("rst.state", 32'(dut.state), 32'(STABLE_LO));
    chk("rst.cnt",   32'(dut.cnt),   32'd0);

    // Release: clean rises on the 6th edge, busy over edges 3..5.
    rst = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      step(1'b1);
      chk3($sformatf("rise%0d", i), (i == 6), (i >= 3 && i <= 5), 1'b0);
    end
    step(1'b1);
    chk3("rise7", 1'b1, 1'b0, 1'b0);

    // 3-cycle low pulse: check runs 3 cycles then aborts, clean holds.
    step(1'b0); chk3("lo3_1", 1'b1, 1'b0, 1'b0);
    step(1'b0); chk3("lo3_2", 1'b1, 1'b0, 1'b0);
    step(1'b0); chk3("lo3_3", 1'b1, 1'b1, 1'b0);
    step(1'b1); chk3("lo3_4", 1'b1, 1'b1, 1'b0);
    chk("lo3_4.cnt", 32'(dut.cnt), 32'd2);
    step(1'b1); chk3("lo3_5", 1'b1, 1'b1, 1'b0);
    chk("lo3_5.cnt", 32'(dut.cnt), 32'd3);
    step(1'b1); chk3("lo3_6", 1'b1, 1'b0, 1'b1);
    step(1'b1); chk3("lo3_7", 1'b1, 1'b0, 1'b0);
    step(1'b1); chk3("lo3_8", 1'b1, 1'b0, 1'b0);

    // 4-cycle low: qualifies, clean falls with no glitch.
    step(1'b0); chk3("lo4_1", 1'b1, 1'b0, 1'b0);
    step(1'b0); chk3("lo4_2", 1'b1, 1'b0, 1'b0);
    step(1'b0); chk3("lo4_3", 1'b1, 1'b1, 1'b0);
    step(1'b0); chk3("lo4_4", 1'b1, 1'b1, 1'b0);
    step(1'b0); chk3("lo4_5", 1'b1, 1'b1, 1'b0);
    step(1'b0); chk3("lo4_6", 1'b0, 1'b0, 1'b0);
    step(1'b0); chk3("lo4_7", 1'b0, 1'b0, 1'b0);

    // 2-cycle high pulse: busy 2 cycles then a single glitch.
    step(1'b1); chk3("hi2_1", 1'b0, 1'b0, 1'b0);
    step(1'b1); chk3("hi2_2", 1'b0, 1'b0, 1'b0);
    step(1'b0); chk3("hi2_3", 1'b0, 1'b1, 1'b0);
    step(1'b0); chk3("hi2_4", 1'b0, 1'b1, 1'b0);
    step(1'b0); chk3("hi2_5", 1'b0, 1'b0, 1'b1);
    step(1'b0); chk3("hi2_6", 1'b0, 1'b0, 1'b0);
    step(1'b0); chk3("hi2_7", 1'b0, 1'b0, 1'b0);

    // Chatter 1,0,1,0 then steady 1: two aborts, restart from cnt=1,
    // clean rises on the 10th edge after 4 consecutive synced ones.
    step(1'b1); chk3("ch1", 1'b0, 1'b0, 1'b0);
    step(1'b0); chk3("ch2", 1'b0, 1'b0, 1'b0);
    step(1'b1); chk3("ch3", 1'b0, 1'b1, 1'b0);
    step(1'b0); chk3("ch4", 1'b0, 1'b0, 1'b1);
    step(1'b1); chk3("ch5", 1'b0, 1'b1, 1'b0);
    chk("ch5.cnt", 32'(dut.cnt), 32'd1);
    step(1'b1); chk3("ch6", 1'b0, 1'b0, 1'b1);
    step(1'b1); chk3("ch7", 1'b0, 1'b1, 1'b0);
    chk("ch7.cnt", 32'(dut.cnt), 32'd1);
    step(1'b1); chk3("ch8", 1'b0, 1'b1, 1'b0);
    step(1'b1); chk3("ch9", 1'b0, 1'b1, 1'b0);
    step(1'b1); chk3("ch10", 1'b1, 1'b0, 1'b0);

    // Return to low via reset, then reset mid-check at cnt=2.
    rst = 1'b1;
    step(1'b0); chk3("rr1", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step(1'b1); chk3("mc1", 1'b0, 1'b0, 1'b0);
    step(1'b1); chk3("mc2", 1'b0, 1'b0, 1'b0);
    step(1'b1); chk3("mc3", 1'b0, 1'b1, 1'b0);
    step(1'b1); chk3("mc4", 1'b0, 1'b1, 1'b0);
    chk("mc4.state", 32'(dut.state), 32'(CHK_HI));
    chk("mc4.cnt",   32'(dut.cnt),   32'd2);
    rst = 1'b1;
    step(1'b1); chk3("mc5", 1'b0, 1'b0, 1'b0);
    chk("mc5.state", 32'(dut.state), 32'(STABLE_LO));
    chk("mc5.cnt",   32'(dut.cnt),   32'd0);
    rst = 1'b0;
    step(1'b0); chk3("mc6", 1'b0, 1'b0, 1'b0);
    step(1'b0); chk3("mc7", 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
